// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA modular exponentiation engine.
package rsa_pkg;

  localparam int RSA_WIDTH_DEFAULT = 16;

  typedef enum logic [2:0] {
    RSA_IDLE = 3'd0,
    RSA_LOAD = 3'd1,
    RSA_SQR  = 3'd2,
    RSA_MUL  = 3'd3,
    RSA_DONE = 3'd4
  } rsa_modexp_state_t;

  // Cycles taken by one serial modular multiply: one load cycle plus one per operand bit.
  function automatic int rsa_mul_cycles(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/rsa_modexp_engine_if.sv
// Request/response bundle between the key source and the modexp engine.
interface rsa_modexp_engine_if #(
  parameter int WIDTH = rsa_pkg::RSA_WIDTH_DEFAULT
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] msg;
  logic [WIDTH-1:0] pub_exp;
  logic [WIDTH-1:0] priv_exp;
  logic [WIDTH-1:0] modulus;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, mode, msg, pub_exp, priv_exp, modulus,
    input  result, busy, done, err
  );

  modport slave (
    input  start, mode, msg, pub_exp, priv_exp, modulus,
    output result, busy, done, err
  );
endinterface

// File: rtl/rsa_modmul_serial.sv
// Bit-serial modular multiplier p = a*b mod n, MSB first, exactly WIDTH+1 cycles per product.
module rsa_modmul_serial #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] p,
  output logic             rdy
);
  localparam int IW = $clog2(WIDTH);
  localparam int PW = WIDTH + 2;

  logic             busy_q, busy_d;
  logic [IW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, n_q, n_d, p_q, p_d;
  logic [PW-1:0]    n_ext, step, s1;
  logic [WIDTH-1:0] s2;

  // With p < n and a < n the doubled sum stays below 3n, so two conditional subtracts reduce it.
  always_comb begin
    n_ext = {2'b00, n_q};
    step  = {1'b0, p_q, 1'b0} + (b_q[cnt_q] ? {2'b00, a_q} : {PW{1'b0}});
    s1    = (step >= n_ext) ? step - n_ext : step;
    s2    = (s1 >= n_ext) ? WIDTH'(s1 - n_ext) : WIDTH'(s1);
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    a_d    = a_q;
    b_d    = b_q;
    n_d    = n_q;
    p_d    = p_q;
    if (busy_q) begin
      p_d   = s2;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) busy_d = 1'b0;
    end else if (go) begin
      busy_d = 1'b1;
      cnt_d  = IW'(WIDTH - 1);
      a_d    = a;
      b_d    = b;
      n_d    = n;
      p_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      n_q    <= '0;
      p_q    <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      b_q    <= b_d;
      n_q    <= n_d;
      p_q    <= p_d;
    end
  end

  assign rdy = busy_q && (cnt_q == '0);
  assign p   = s2;
endmodule

// File: rtl/rsa_modexp_engine.sv
// Left-to-right square-and-multiply modexp engine (msg^exp mod n) with range check.
// RSA_MODEXP_EARLY_EXIT_EN starts the scan at the highest set exponent bit instead of bit WIDTH-1.
module rsa_modexp_engine
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  rsa_modexp_engine_if.slave bus
);
  localparam int IW = $clog2(WIDTH);

  localparam logic [2:0] ST_IDLE = 3'(RSA_IDLE);
  localparam logic [2:0] ST_LOAD = 3'(RSA_LOAD);
  localparam logic [2:0] ST_SQR  = 3'(RSA_SQR);
  localparam logic [2:0] ST_MUL  = 3'(RSA_MUL);
  localparam logic [2:0] ST_DONE = 3'(RSA_DONE);

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] msg_q, msg_d, n_q, n_d, exp_q, exp_d, acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             mul_active_q, mul_active_d;
  logic             err_pend_q, err_pend_d;
  logic             err_q, err_d, done_q, done_d, busy_q, busy_d;

  logic             mul_go, mul_rdy;
  logic [WIDTH-1:0] mul_a, mul_p;

`ifdef RSA_MODEXP_EARLY_EXIT_EN
  logic [IW-1:0] msb_idx;
  always_comb begin
    msb_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (exp_q[i]) msb_idx = IW'(i);
    end
  end
`endif

  assign mul_a = (state_q == ST_MUL) ? msg_q : acc_q;

  rsa_modmul_serial #(.WIDTH(WIDTH)) u_modmul (
    .clk   (clk),
    .rst_n (rst_n),
    .go    (mul_go),
    .a     (mul_a),
    .b     (acc_q),
    .n     (n_q),
    .p     (mul_p),
    .rdy   (mul_rdy)
  );

  always_comb begin
    state_d      = state_q;
    msg_d        = msg_q;
    n_d          = n_q;
    exp_d        = exp_q;
    acc_d        = acc_q;
    idx_d        = idx_q;
    mul_active_d = mul_active_q;
    err_pend_d   = err_pend_q;
    result_d     = result_q;
    err_d        = err_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    mul_go       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          msg_d   = bus.msg;
          n_d     = bus.modulus;
          exp_d   = bus.mode ? bus.priv_exp : bus.pub_exp;
          busy_d  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if ((n_q < WIDTH'(2)) || (msg_q >= n_q)) begin
          acc_d      = '0;
          err_pend_d = 1'b1;
          state_d    = ST_DONE;
        end else begin
          acc_d      = WIDTH'(1);
          err_pend_d = 1'b0;
`ifdef RSA_MODEXP_EARLY_EXIT_EN
          // The leading square would only square acc=1, so go straight to the multiply.
          if (exp_q == '0) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = msb_idx;
            state_d = ST_MUL;
          end
`else
          idx_d   = IW'(WIDTH - 1);
          state_d = ST_SQR;
`endif
        end
      end
      ST_SQR, ST_MUL: begin
        if (!mul_active_q) begin
          mul_go       = 1'b1;
          mul_active_d = 1'b1;
        end else if (mul_rdy) begin
          mul_active_d = 1'b0;
          acc_d        = mul_p;
          if ((state_q == ST_SQR) && exp_q[idx_q]) begin
            state_d = ST_MUL;
          end else if (idx_q == '0) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = ST_SQR;
          end
        end
      end
      ST_DONE: begin
        result_d = acc_q;
        err_d    = err_pend_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      msg_q        <= '0;
      n_q          <= '0;
      exp_q        <= '0;
      acc_q        <= '0;
      idx_q        <= '0;
      mul_active_q <= 1'b0;
      err_pend_q   <= 1'b0;
      result_q     <= '0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      msg_q        <= msg_d;
      n_q          <= n_d;
      exp_q        <= exp_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      mul_active_q <= mul_active_d;
      err_pend_q   <= err_pend_d;
      result_q     <= result_d;
      err_q        <= err_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.result = result_q;
  assign bus.err    = err_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;
endmodule

// File: tb/tb_rsa_modexp_engine.sv
// Directed bench for rsa_modexp_engine at WIDTH=16 with hand-computed results and latencies.
module tb_rsa_modexp_engine;
`ifdef RSA_MODEXP_EARLY_EXIT_EN
  localparam int L_E17 = 104;
  localparam int L_D   = 274;
  localparam int L_Z   = 2;
  localparam int L_E13 = 104;
  localparam int L_E5  = 70;
  localparam int L_E3  = 53;
  localparam int L_E2  = 36;
`else
  localparam int L_E17 = 308;
  localparam int L_D   = 359;
  localparam int L_Z   = 274;
  localparam int L_E13 = 325;
  localparam int L_E5  = 308;
  localparam int L_E3  = 308;
  localparam int L_E2  = 291;
`endif
  localparam int L_ERR = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  rsa_modexp_engine_if #(.WIDTH(16)) bus ();

  rsa_modexp_engine #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic run(input string tag, input bit md, input int m, input int e, input int d,
                     input int n, input int exp_res, input bit exp_err, input int exp_lat,
                     input bit poke, input int rst_at);
    int edges;
    bit got_done;
    bit busy_gap;
    edges    = 0;
    got_done = 1'b0;
    busy_gap = 1'b0;
    bus.mode     = md;
    bus.msg      = m[15:0];
    bus.pub_exp  = e[15:0];
    bus.priv_exp = d[15:0];
    bus.modulus  = n[15:0];
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, "_busy_rise"}, bus.busy, 1);
    while (!got_done && edges < 2000) begin
      if (rst_at != 0 && edges == rst_at - 1) rst_n = 1'b0;
      if (poke && edges == 50) begin
        bus.start    = 1'b1;
        bus.mode     = ~md;
        bus.msg      = 16'd5;
        bus.modulus  = 16'd7;
        bus.pub_exp  = 16'd3;
        bus.priv_exp = 16'd3;
      end
      if (poke && edges == 51) bus.start = 1'b0;
      if (poke && edges == exp_lat - 1) bus.start = 1'b1;
      @(posedge clk); edges++; #1;
      if (rst_at != 0 && edges == rst_at) begin
        check({tag, "_rst_busy"}, bus.busy, 0);
        check({tag, "_rst_done"}, bus.done, 0);
        check({tag, "_rst_result"}, bus.result, 0);
        check({tag, "_rst_err"}, bus.err, 0);
        rst_n = 1'b1;
        $display("[TB] %s: reset asserted at edge %0d", tag, edges);
        return;
      end
      if (bus.done) got_done = 1'b1;
      else if (!bus.busy) busy_gap = 1'b1;
    end
    bus.start = 1'b0;
    check({tag, "_done_seen"}, got_done, 1);
    check({tag, "_latency"}, edges, exp_lat);
    check({tag, "_result"}, bus.result, exp_res);
    check({tag, "_err"}, bus.err, exp_err);
    check({tag, "_busy_in_done"}, bus.busy, 0);
    check({tag, "_busy_gap"}, busy_gap, 0);
    if (poke) begin
      @(posedge clk); #1;
      check({tag, "_no_rerun_busy"}, bus.busy, 0);
      check({tag, "_no_rerun_done"}, bus.done, 0);
    end
    $display("[TB] %s: result=%0d err=%0d latency=%0d", tag, bus.result, bus.err, edges);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.mode     = 1'b0;
    bus.msg      = '0;
    bus.pub_exp  = '0;
    bus.priv_exp = '0;
    bus.modulus  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_result", bus.result, 0);
    check("reset_err", bus.err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run("enc_e17",     1'b0, 65,    17, 999,  3233,  2790,  1'b0, L_E17, 1'b0, 0);
    run("dec_d2753",   1'b1, 2790,  5,   2753, 3233,  65,    1'b0, L_D,   1'b0, 0);
    run("err_msg_eq_n", 1'b0, 3233, 17,  0,    3233,  0,     1'b1, L_ERR, 1'b0, 0);
    run("err_n1",      1'b0, 0,     17,  0,    1,     0,     1'b1, L_ERR, 1'b0, 0);
    run("err_n0",      1'b1, 0,     0,   9,    0,     0,     1'b1, L_ERR, 1'b0, 0);
    run("exp_zero",    1'b0, 100,   0,   77,   3233,  1,     1'b0, L_Z,   1'b0, 0);
    run("e13_n497",    1'b0, 4,     13,  0,    497,   445,   1'b0, L_E13, 1'b0, 0);
    run("n2_min",      1'b1, 1,     0,   5,    2,     1,     1'b0, L_E5,  1'b0, 0);
    run("wide_n65521", 1'b0, 65520, 3,   0,    65521, 65520, 1'b0, L_E3,  1'b0, 0);
    run("msg_n_minus1", 1'b0, 3232, 2,   0,    3233,  1,     1'b0, L_E2,  1'b0, 0);
    run("poke_start",  1'b0, 65,    17,  999,  3233,  2790,  1'b0, L_E17, 1'b1, 0);
    run("mid_reset",   1'b0, 65,    17,  999,  3233,  2790,  1'b0, L_E17, 1'b0, 100);
    run("after_reset", 1'b1, 2790,  5,   2753, 3233,  65,    1'b0, L_D,   1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
